pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 122 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: ext_hold freeze, branch flush, multi-cycle
// mult/div stall and load-use interlock for a classic 5-stage pipeline.
// Optional feature: define HAZ_STALL_COUNTER_EN to add a 32-bit stall_count
// output that counts front-end stall cycles (pc_write low).
module pipeline_hazard_controller #(
  parameter int unsigned MDU_LATENCY = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  input  logic       if_id_uses_rt,
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rt,
  input  logic       branch_taken,
  input  logic       mdu_start,
  input  logic       ext_hold,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       id_ex_write,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       mdu_done,
`ifdef HAZ_STALL_COUNTER_EN
  output logic [31:0] stall_count,
`endif
  output logic [1:0] state
);

  localparam int unsigned CNT_W = 8;
  localparam logic [1:0]  RUN      = 2'd0;
  localparam logic [1:0]  MDU_WAIT = 2'd1;
  // The start cycle is the first stall cycle and the zero-count cycle the last.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 2);

  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             load_use_c;

  // Load in EX writing a register the ID instruction reads; $0 never hazards.
  assign load_use_c = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                      ((id_ex_rt == if_id_rs) ||
                       (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  // State and MDU counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      cnt_q <= cnt_d;
    end
  end

  // Next-state: hold freezes everything, unused encodings fall back to RUN.
  always_comb begin
    state_d = state;
    cnt_d   = cnt_q;
    case (state)
      RUN: begin
        if (!ext_hold && !branch_taken && mdu_start) begin
          state_d = MDU_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      MDU_WAIT: begin
        if (!ext_hold) begin
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs from state, counter and current inputs in priority order.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mdu_done    = 1'b0;
    if (!reset && ((state == RUN) || (state == MDU_WAIT))) begin
      if (ext_hold) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_write = 1'b0;
      end else if (state == MDU_WAIT) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_write = 1'b0;
        mdu_done    = (cnt_q == '0);
      end else if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (mdu_start) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_write = 1'b0;
      end else if (load_use_c) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

`ifdef HAZ_STALL_COUNTER_EN
  // Count front-end stall cycles, wrapping naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset)         stall_count <= '0;
    else if (!pc_write) stall_count <= stall_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (MDU_LATENCY = 8).
// Output vector: {pc_write, if_id_write, id_ex_write, if_id_flush,
//                 id_ex_flush, mdu_done, state[1:0]}.
module tb_pipeline_hazard_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
  logic       if_id_uses_rt, id_ex_mem_read, branch_taken, mdu_start, ext_hold;
  logic       pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, mdu_done;
  logic [1:0] state;
`ifdef HAZ_STALL_COUNTER_EN
  logic [31:0] stall_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [7:0] V_RUN   = 8'he0;
  localparam logic [7:0] V_LU    = 8'h28;
  localparam logic [7:0] V_BR    = 8'hf8;
  localparam logic [7:0] V_STALL = 8'h00;
  localparam logic [7:0] V_WAIT  = 8'h01;
  localparam logic [7:0] V_DONE  = 8'h05;

  pipeline_hazard_controller #(.MDU_LATENCY(8)) dut (
    .clock(clock), .reset(reset),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .branch_taken(branch_taken), .mdu_start(mdu_start), .ext_hold(ext_hold),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mdu_done(mdu_done),
`ifdef HAZ_STALL_COUNTER_EN
    .stall_count(stall_count),
`endif
    .state(state)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] outs();
    return {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, mdu_done, state};
  endfunction

  task automatic idle();
    reset = 1'b0; if_id_rs = 5'd0; if_id_rt = 5'd0; if_id_uses_rt = 1'b0;
    id_ex_mem_read = 1'b0; id_ex_rt = 5'd0; branch_taken = 1'b0;
    mdu_start = 1'b0; ext_hold = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    idle(); reset = 1'b1; mdu_start = 1'b1; branch_taken = 1'b1; ext_hold = 1'b1;
    #1 n_cmp++;
    if (outs() !== V_RUN) begin n_bad++; $display("FAIL reset_outputs: got %h want %h", outs(), V_RUN); end
    @(negedge clock);
    idle();
    #1 n_cmp++;
    if (outs() !== V_RUN) begin n_bad++; $display("FAIL reset_release: got %h want %h", outs(), V_RUN); end
`ifdef HAZ_STALL_COUNTER_EN
    n_cmp++;
    if (stall_count !== 32'd0) begin n_bad++; $display("FAIL reset_stall_count: got %0d want 0", stall_count); end
`endif
  endtask

  task automatic test_load_use();
    @(negedge clock);
    idle(); id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
    #1 n_cmp++;
    if (outs() !== V_LU) begin n_bad++; $display("FAIL load_use_rs: got %h want %h", outs(), V_LU); end
    @(negedge clock);
    idle(); if_id_rs = 5'd5;
    #1 n_cmp++;
    if (outs() !== V_RUN) begin n_bad++; $display("FAIL load_use_release: got %h want %h", outs(), V_RUN); end
    @(negedge clock);
    idle(); id_ex_mem_read = 1'b1; id_ex_rt = 5'd9; if_id_rs = 5'd3; if_id_rt = 5'd9; if_id_uses_rt = 1'b1;
    #1 n_cmp++;
    if (outs() !== V_LU) begin n_bad++; $display("FAIL load_use_rt: got %h want %h", outs(), V_LU); end
  endtask

  task automatic test_no_stall();
    @(negedge clock);
    idle(); id_ex_mem_read = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0; if_id_uses_rt = 1'b1;
    #1 n_cmp++;
    if (outs() !== V_RUN) begin n_bad++; $display("FAIL no_stall_r0: got %h want %h", outs(), V_RUN); end
    @(negedge clock);
    idle(); id_ex_mem_read = 1'b1; id_ex_rt = 5'd7; if_id_rs = 5'd3; if_id_rt = 5'd7;
    #1 n_cmp++;
    if (outs() !== V_RUN) begin n_bad++; $display("FAIL no_stall_rt_unused: got %h want %h", outs(), V_RUN); end
    @(negedge clock);
    idle(); id_ex_rt = 5'd4; if_id_rs = 5'd4;
    #1 n_cmp++;
    if (outs() !== V_RUN) begin n_bad++; $display("FAIL no_stall_not_load: got %h want %h", outs(), V_RUN); end
  endtask

  task automatic test_mdu();
    logic [7:0] exp;
    @(negedge clock);
    idle(); mdu_start = 1'b1;
    #1 n_cmp++;
    if (outs() !== V_STALL) begin n_bad++; $display("FAIL mdu_cycle1: got %h want %h", outs(), V_STALL); end
    for (int c = 2; c <= 8; c++) begin
      @(negedge clock);
      idle();
      if (c == 3 || c == 4) begin mdu_start = 1'b1; branch_taken = 1'b1; end
      exp = (c == 8) ? V_DONE : V_WAIT;
      #1 n_cmp++;
      if (outs() !== exp) begin n_bad++; $display("FAIL mdu_cycle%0d: got %h want %h", c, outs(), exp); end
    end
    @(negedge clock);
    idle();
    #1 n_cmp++;
    if (outs() !== V_RUN) begin n_bad++; $display("FAIL mdu_end: got %h want %h", outs(), V_RUN); end
  endtask

  task automatic test_mdu_hold();
    logic [7:0] exp;
    @(negedge clock);
    idle(); mdu_start = 1'b1;
    #1 n_cmp++;
    if (outs() !== V_STALL) begin n_bad++; $display("FAIL hold_cycle1: got %h want %h", outs(), V_STALL); end
    for (int c = 2; c <= 11; c++) begin
      @(negedge clock);
      idle();
      if (c >= 4 && c <= 6) ext_hold = 1'b1;
      exp = (c == 11) ? V_DONE : V_WAIT;
      #1 n_cmp++;
      if (outs() !== exp) begin n_bad++; $display("FAIL hold_cycle%0d: got %h want %h", c, outs(), exp); end
    end
    @(negedge clock);
    idle();
    #1 n_cmp++;
    if (outs() !== V_RUN) begin n_bad++; $display("FAIL hold_end: got %h want %h", outs(), V_RUN); end
  endtask

  task automatic test_hold_run();
    @(negedge clock);
    idle(); ext_hold = 1'b1; mdu_start = 1'b1; id_ex_mem_read = 1'b1; id_ex_rt = 5'd6; if_id_rs = 5'd6;
    #1 n_cmp++;
    if (outs() !== V_STALL) begin n_bad++; $display("FAIL hold_run: got %h want %h", outs(), V_STALL); end
    @(negedge clock);
    idle();
    #1 n_cmp++;
    if (outs() !== V_RUN) begin n_bad++; $display("FAIL hold_run_frozen: got %h want %h", outs(), V_RUN); end
  endtask

  task automatic test_branch_priority();
    @(negedge clock);
    idle(); branch_taken = 1'b1; mdu_start = 1'b1; id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8;
    #1 n_cmp++;
    if (outs() !== V_BR) begin n_bad++; $display("FAIL branch_priority: got %h want %h", outs(), V_BR); end
    @(negedge clock);
    idle();
    #1 n_cmp++;
    if (outs() !== V_RUN) begin n_bad++; $display("FAIL branch_stays_run: got %h want %h", outs(), V_RUN); end
  endtask

  task automatic test_reset_mid_mdu();
    @(negedge clock);
    idle(); mdu_start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      idle();
      #1 n_cmp++;
      if (outs() !== V_WAIT) begin n_bad++; $display("FAIL rst_mdu_wait%0d: got %h want %h", c, outs(), V_WAIT); end
    end
    @(negedge clock);
    idle(); reset = 1'b1;
    #1 n_cmp++;
    if (outs() !== 8'he1) begin n_bad++; $display("FAIL rst_mdu_during: got %h want %h", outs(), 8'he1); end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      idle();
      #1 n_cmp++;
      if (outs() !== V_RUN) begin n_bad++; $display("FAIL rst_mdu_after%0d: got %h want %h", c, outs(), V_RUN); end
`ifdef HAZ_STALL_COUNTER_EN
      if (c == 1) begin
        n_cmp++;
        if (stall_count !== 32'd0) begin n_bad++; $display("FAIL rst_mdu_stall_count: got %0d want 0", stall_count); end
      end
`endif
    end
  endtask

`ifdef HAZ_STALL_COUNTER_EN
  task automatic test_stall_count();
    @(negedge clock);
    idle(); id_ex_mem_read = 1'b1; id_ex_rt = 5'd2; if_id_rs = 5'd2;
    @(negedge clock);
    idle(); ext_hold = 1'b1;
    @(negedge clock);
    idle(); branch_taken = 1'b1;
    @(negedge clock);
    idle();
    #1 n_cmp++;
    if (stall_count !== 32'd2) begin n_bad++; $display("FAIL stall_count: got %0d want 2", stall_count); end
  endtask
`endif

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_no_stall();
    test_mdu();
    test_mdu_hold();
    test_hold_run();
    test_branch_priority();
    test_reset_mid_mdu();
`ifdef HAZ_STALL_COUNTER_EN
    test_stall_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
